// File: rtl/nco_pkg.sv
// nco_pkg: default sizes, cfg_sel encodings and channel-index width helper for nco_multi.
package nco_pkg;
    localparam int NCO_N_CH_DEF  = 4;
    localparam int NCO_ACC_W_DEF = 32;
    localparam logic NCO_SEL_STEP = 1'b0;
    localparam logic NCO_SEL_DUTY = 1'b1;
    function automatic int nco_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/nco_channel.sv
// nco_channel: one phase accumulator with wrap-applied pending step (and duty/PWM under NCO_PWM_EN).
module nco_channel
    import nco_pkg::*;
#(
    parameter int ACC_W = NCO_ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_step,
`ifdef NCO_PWM_EN
    input  logic             wr_duty,
    output logic             pwm,
`endif
    input  logic [ACC_W-1:0] wr_data,
    output logic             busy,
    output logic             sq,
    output logic             tick,
    output logic [ACC_W-1:0] acc
);
    logic [ACC_W-1:0] acc_q, acc_d, step_q, step_d, pstep_q, pstep_d;
    logic             spend_q, spend_d, tick_q, tick_d, apply;
    logic [ACC_W:0]   sum;
    // pending values take effect only where the waveform restarts: wrap, sync or while idle
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, step_q};
        apply   = sync || !en || sum[ACC_W];
        acc_d   = sync ? '0 : en ? sum[ACC_W-1:0] : acc_q;
        tick_d  = !sync && en && sum[ACC_W];
        step_d  = (spend_q && apply) ? pstep_q : step_q;
        spend_d = wr_step || (spend_q && !apply);
        pstep_d = wr_step ? wr_data : pstep_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            step_q  <= '0;
            pstep_q <= '0;
            spend_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            step_q  <= step_d;
            pstep_q <= pstep_d;
            spend_q <= spend_d;
            tick_q  <= tick_d;
        end
    end
`ifdef NCO_PWM_EN
    logic [ACC_W-1:0] duty_q, duty_d, pduty_q, pduty_d;
    logic             dpend_q, dpend_d, pwm_q, pwm_d;
    always_comb begin
        duty_d  = (dpend_q && apply) ? pduty_q : duty_q;
        dpend_d = wr_duty || (dpend_q && !apply);
        pduty_d = wr_duty ? wr_data : pduty_q;
        pwm_d   = acc_q < duty_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q  <= '0;
            pduty_q <= '0;
            dpend_q <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            duty_q  <= duty_d;
            pduty_q <= pduty_d;
            dpend_q <= dpend_d;
            pwm_q   <= pwm_d;
        end
    end
    assign busy = spend_q || dpend_q;
    assign pwm  = pwm_q;
`else
    assign busy = spend_q;
`endif
    assign acc  = acc_q;
    assign sq   = acc_q[ACC_W-1];
    assign tick = tick_q;
endmodule

// File: rtl/nco_multi.sv
// nco_multi: N_CH NCO channels with cfg decode, cfg_ready mux and phase_sync fan-out; NCO_PWM_EN adds cfg_sel/pwm_out.
module nco_multi
    import nco_pkg::*;
#(
    parameter int N_CH  = NCO_N_CH_DEF,
    parameter int ACC_W = NCO_ACC_W_DEF,
    parameter int CH_W  = nco_clog2(N_CH)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [N_CH-1:0]       ch_en,
    input  logic                  phase_sync,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_chan,
    input  logic [ACC_W-1:0]      cfg_step,
`ifdef NCO_PWM_EN
    input  logic                  cfg_sel,
    output logic [N_CH-1:0]       pwm_out,
`endif
    output logic [N_CH-1:0]       sq_out,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH*ACC_W-1:0] phase
);
    logic [N_CH-1:0]      busy, wr;
    logic [(1<<CH_W)-1:0] busy_x;
    logic                 sel;
`ifdef NCO_PWM_EN
    assign sel = cfg_sel;
`else
    assign sel = NCO_SEL_STEP;
`endif
    // unpopulated channel indices read as not busy, so writes to them are accepted and dropped
    always_comb begin
        busy_x           = '0;
        busy_x[N_CH-1:0] = busy;
        cfg_ready        = !busy_x[cfg_chan];
        for (int i = 0; i < N_CH; i++) wr[i] = cfg_valid && cfg_ready && (cfg_chan == CH_W'(i));
    end
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        nco_channel #(.ACC_W(ACC_W)) u_ch (
            .clk     (sys_clk),
            .rst     (sys_rst),
            .en      (ch_en[i]),
            .sync    (phase_sync),
            .wr_step (wr[i] && sel == NCO_SEL_STEP),
`ifdef NCO_PWM_EN
            .wr_duty (wr[i] && sel == NCO_SEL_DUTY),
            .pwm     (pwm_out[i]),
`endif
            .wr_data (cfg_step),
            .busy    (busy[i]),
            .sq      (sq_out[i]),
            .tick    (tick[i]),
            .acc     (phase[i*ACC_W +: ACC_W])
        );
    end
endmodule
